// File: rtl/noc_pkg.sv
// Shared definitions for the NoC port arbiter slice.
//   FLIT_W/ADDR_W/DATA_W : flit geometry, flit = {data, addr}
//   flit_t               : packed view of one flit
//   PORT_*               : requester index of each neighbour port and the core
//   src_t                : winner index type
//   arb_state_e          : output-stage state (EMPTY / FULL)
package noc_pkg;

    localparam int unsigned FLIT_W = 11;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 7;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } flit_t;

    localparam int unsigned PORT_0    = 0;
    localparam int unsigned PORT_1    = 1;
    localparam int unsigned PORT_2    = 2;
    localparam int unsigned PORT_3    = 3;
    localparam int unsigned PORT_CORE = 4;

    typedef logic [2:0] src_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   : request vector, one bit per requester
//   ptr_i   : index of the last winner; search starts at ptr_i+1
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester (0 when no request)
//   any_o   : at least one request is present
module noc_rr_pick #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned SRC_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [SRC_W-1:0]   idx_o,
    output logic               any_o
);

    logic [SRC_W-1:0] cand;

    // Walk ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = SRC_W'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter sharing one router output link among NUM_REQ
// requesters (index 0..3 neighbour ports, index 4 the local core), with a
// one-entry registered output stage.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : per-requester valid
//   req_flit    : flattened flits, requester i at [i*FLIT_W +: FLIT_W]
//   req_ready   : one-hot accept strobe (combinational)
//   out_valid   : output stage holds a flit
//   out_flit    : registered winning flit
//   out_src     : index of the requester that supplied out_flit
//   out_ready   : downstream accept
//   stat_grants : per-requester 16-bit saturating grant counters
//                 (present only when NOC_ARB_STATS_EN is defined)
module noc_port_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned FLIT_W  = 11,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned SRC_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [FLIT_W-1:0]         out_flit,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready
`ifdef NOC_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]     stat_grants
`endif
);

    import noc_pkg::*;

    if (((1 << SRC_W) < NUM_REQ) || (ADDR_W >= FLIT_W)) begin : g_bad_cfg
        $error("noc_port_arbiter: invalid SRC_W/ADDR_W for NUM_REQ/FLIT_W");
    end

    arb_state_e             state_q, state_d;
    logic [FLIT_W-1:0]      flit_q, flit_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0]     grant;
    logic [SRC_W-1:0]       win_idx;
    logic                   any_req;
    logic                   take;
    logic [FLIT_W-1:0]      flits [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign flits[g] = req_flit[g*FLIT_W +: FLIT_W];
    end

    noc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (any_req)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    // Next state: a load keeps/enters FULL; a drain with no refill empties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (take) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !take) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Outputs: a grant is offered whenever the stage is empty or draining.
    always_comb begin
        take      = 1'b0;
        req_ready = '0;
        if (!reset && any_req && (state_q == ST_EMPTY || out_ready)) begin
            take      = 1'b1;
            req_ready = grant;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_flit  = flit_q;
    assign out_src   = src_q;

    // Output stage and pointer only move on an accepted grant.
    always_comb begin
        flit_d   = flit_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            flit_d   = flits[win_idx];
            src_d    = win_idx;
            rr_ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= SRC_W'(NUM_REQ - 1);
        end else begin
            flit_q   <= flit_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef NOC_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] cnt_q;
        always_ff @(posedge clk) begin
            if (reset)                              cnt_q <= '0;
            else if (req_ready[g] && cnt_q != '1)   cnt_q <= cnt_q + 16'd1;
        end
        assign stat_grants[g*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed, table-driven bench for noc_port_arbiter plus a short randomised
// run against a small reference model and, with NOC_ARB_STATS_EN, a counter
// saturation sequence.
module tb_noc_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  req_valid;
    logic [54:0] req_flit;
    logic [4:0]  req_ready;
    logic        out_valid;
    logic [10:0] out_flit;
    logic [2:0]  out_src;
    logic        out_ready;
`ifdef NOC_ARB_STATS_EN
    logic [79:0] stat_grants;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [10:0] fl [5];

    always #5 clk = ~clk;

    noc_port_arbiter #(
        .NUM_REQ (5),
        .FLIT_W  (11),
        .ADDR_W  (4),
        .SRC_W   (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_flit    (req_flit),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_flit    (out_flit),
        .out_src     (out_src),
        .out_ready   (out_ready)
`ifdef NOC_ARB_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rv;
        logic        ordy;
        logic [4:0]  e_rdy;
        logic        e_ov;
        logic        chk_d;
        logic [10:0] e_flit;
        logic [2:0]  e_src;
    } vec_t;

    vec_t tbl [25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference round-robin search: scan upward from ptr+1 with wrap.
    function automatic logic [4:0] ref_pick(input logic [4:0] rv, input int ptr);
        int c;
        c = ptr;
        repeat (5) begin
            c = (c == 4) ? 0 : c + 1;
            if (rv[c]) return 5'(1 << c);
        end
        return 5'b0;
    endfunction

    function automatic int onehot_idx(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return 0;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ptr_m, src_m;
        logic ov_m;
        logic [4:0] eg;

        fl[0] = 11'h7A5; fl[1] = 11'h123; fl[2] = 11'h456;
        fl[3] = 11'h789; fl[4] = 11'h3C4;
        req_flit = {fl[4], fl[3], fl[2], fl[1], fl[0]};

        //              rst rv        ordy e_rdy     ov chk flit     src
        tbl[0]  = '{1'b0, 5'b00001, 1'b1, 5'b00001, 1'b0, 1'b0, 11'h000, 3'd0};
        tbl[1]  = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b1, 11'h7A5, 3'd0};
        tbl[2]  = '{1'b0, 5'b11111, 1'b1, 5'b00010, 1'b0, 1'b0, 11'h000, 3'd0};
        tbl[3]  = '{1'b0, 5'b11111, 1'b1, 5'b00100, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[4]  = '{1'b0, 5'b11111, 1'b1, 5'b01000, 1'b1, 1'b1, 11'h456, 3'd2};
        tbl[5]  = '{1'b0, 5'b11111, 1'b1, 5'b10000, 1'b1, 1'b1, 11'h789, 3'd3};
        tbl[6]  = '{1'b0, 5'b11111, 1'b1, 5'b00001, 1'b1, 1'b1, 11'h3C4, 3'd4};
        tbl[7]  = '{1'b0, 5'b11111, 1'b1, 5'b00010, 1'b1, 1'b1, 11'h7A5, 3'd0};
        tbl[8]  = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[9]  = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[10] = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[11] = '{1'b0, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[12] = '{1'b0, 5'b10000, 1'b1, 5'b10000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[13] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b1, 11'h3C4, 3'd4};
        tbl[14] = '{1'b0, 5'b00010, 1'b1, 5'b00010, 1'b0, 1'b0, 11'h000, 3'd0};
        tbl[15] = '{1'b0, 5'b01010, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[16] = '{1'b0, 5'b01010, 1'b1, 5'b01000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[17] = '{1'b0, 5'b00000, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h789, 3'd3};
        tbl[18] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b1, 11'h789, 3'd3};
        tbl[19] = '{1'b0, 5'b00101, 1'b1, 5'b00001, 1'b0, 1'b0, 11'h000, 3'd0};
        tbl[20] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b1, 11'h7A5, 3'd0};
        tbl[21] = '{1'b0, 5'b11111, 1'b0, 5'b00010, 1'b0, 1'b0, 11'h000, 3'd0};
        tbl[22] = '{1'b1, 5'b11111, 1'b0, 5'b00000, 1'b1, 1'b1, 11'h123, 3'd1};
        tbl[23] = '{1'b0, 5'b11111, 1'b1, 5'b00001, 1'b0, 1'b1, 11'h000, 3'd0};
        tbl[24] = '{1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b1, 11'h7A5, 3'd0};

        // Reset sequence and reset-state check
        reset = 1'b1; req_valid = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset req_ready", 32'(req_ready), 32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset out_flit",  32'(out_flit),  32'h0);
        check("reset out_src",   32'(out_src),   32'h0);
        @(posedge clk);

        // Directed vector table: inputs applied mid-cycle, outputs checked
        // before the following rising edge.
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            reset     = tbl[i].rst;
            req_valid = tbl[i].rv;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].chk_d) begin
                check($sformatf("row%0d out_flit", i), 32'(out_flit), 32'(tbl[i].e_flit));
                check($sformatf("row%0d out_src", i),  32'(out_src),  32'(tbl[i].e_src));
            end
            @(posedge clk);
        end

        // Random traffic against the reference model. After the table the
        // stage is empty and the last winner was requester 0.
        ov_m = 1'b0; ptr_m = 0; src_m = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            req_valid = 5'($urandom_range(0, 31));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            eg = (!ov_m || out_ready) ? ref_pick(req_valid, ptr_m) : 5'b0;
            check($sformatf("rnd%0d req_ready", i), 32'(req_ready), 32'(eg));
            check($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(ov_m));
            if (ov_m) begin
                check($sformatf("rnd%0d out_src", i),  32'(out_src),  32'(src_m));
                check($sformatf("rnd%0d out_flit", i), 32'(out_flit), 32'(fl[src_m]));
            end
            if (eg != 5'b0) begin
                ov_m  = 1'b1;
                src_m = onehot_idx(eg);
                ptr_m = src_m;
            end else if (ov_m && out_ready) begin
                ov_m = 1'b0;
            end
            @(posedge clk);
        end

`ifdef NOC_ARB_STATS_EN
        // Saturation: 70000 back-to-back grants to requester 2.
        @(negedge clk);
        reset = 1'b1; req_valid = '0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = 5'b00100;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("stat req2 saturated", 32'(stat_grants[2*16 +: 16]), 32'hFFFF);
        check("stat req0", 32'(stat_grants[0*16 +: 16]), 32'h0);
        check("stat req1", 32'(stat_grants[1*16 +: 16]), 32'h0);
        check("stat req3", 32'(stat_grants[3*16 +: 16]), 32'h0);
        check("stat req4", 32'(stat_grants[4*16 +: 16]), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_port_arbiter.md
Name: noc_port_arbiter

Overview:
- Clocked round-robin arbiter that shares one router output link among up to NUM_REQ requesters.
- Requesters are the four neighbour-router path-computation outputs plus the local core.
- Each requester offers an 11-bit flit {data[6:0], addr[3:0]} using valid/ready.
- The block picks one winner per transfer, registers its flit into a one-entry output stage and drives the outgoing link. It sits between the path-computation split outputs and a link/port.

Parameters:
- NUM_REQ, 5: number of requesters. Index 0..3 are router inputs, index 4 is the core.
- FLIT_W, 11: flit width, {data[FLIT_W-1:ADDR_W], addr[ADDR_W-1:0]}.
- ADDR_W, 4: address field width.
- SRC_W, 3: width of the winner index; must satisfy 2**SRC_W >= NUM_REQ.

Ports:
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_flit  in  NUM_REQ*FLIT_W  flattened flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- out_valid  out  1  output stage holds a flit.
- out_flit  out  FLIT_W  registered winning flit.
- out_src  out  SRC_W  index of the requester that supplied out_flit.
- out_ready  in  1  downstream accept.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: out_valid=0, out_flit=0, out_src=0, rr_ptr=NUM_REQ-1 (requester 0 has first priority after reset). req_ready=0 while reset is high.
- Transfers occur on a rising clk edge when valid and ready are both 1, on both sides.
- State EMPTY (out_valid=0):
  - If any req_valid is set, pick winner w = first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready = onehot(w), combinational, same cycle.
  - Next edge: out_flit<=req_flit[w], out_src<=w, out_valid<=1, rr_ptr<=w, go to FULL.
  - If no req_valid is set, stay in EMPTY with req_ready=0.
- State FULL (out_valid=1):
  - out_flit and out_src are stable until accepted.
  - If out_ready=0: req_ready=0, stay in FULL.
  - If out_ready=1 and some req_valid is set: arbitrate as in EMPTY and load the winner on the same edge (back-to-back, one flit per cycle). Stay in FULL.
  - If out_ready=1 and no req_valid is set: out_valid<=0, go to EMPTY.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 flit per cycle.
- req_ready depends only on req_valid, rr_ptr, out_valid and out_ready. It never depends on req_flit.
- At most one req_ready bit is high in any cycle. req_ready is never high for a requester whose req_valid is 0.
- Fairness: a continuously valid requester is granted within NUM_REQ grants.
- rr_ptr wraps from NUM_REQ-1 to 0. It updates only on an accepted grant.
- Requesters must hold req_valid and req_flit until accepted. A requester that drops valid before being accepted is simply skipped.
- Reset asserted mid-operation: any held flit is discarded; all state returns to reset values on that edge.
- The flit is passed through unmodified; no address decode is performed here.

Optional Feature:
- Macro: NOC_ARB_STATS_EN.
- Defined:
  - Adds output port stat_grants, NUM_REQ*16 bits: per-requester 16-bit grant counters.
  - A counter increments on each accepted grant to its requester and saturates at 16'hFFFF.
  - Counters clear on reset. They have no effect on arbitration.
- Not defined: the port and all counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W=11, ADDR_W=4, DATA_W=7;
  - flit_t packed struct {data[6:0], addr[3:0]};
  - port index constants: PORT_0..PORT_3=0..3, PORT_CORE=4;
  - src_t logic[2:0].
- One sub-module, noc_rr_pick: purely combinational, takes (req vector, rr_ptr) and returns a one-hot grant, the winner index and an any-request flag.
- noc_port_arbiter holds the output register, rr_ptr, handshake logic and the optional counters.

Test Plan:
- Reset, then req_valid=5'b00001 with flit 11'h7A5, out_ready=1 -> req_ready=00001 in the same cycle; next cycle out_valid=1, out_flit=11'h7A5, out_src=0.
- All five requesters continuously valid, out_ready=1 -> out_src sequence 0,1,2,3,4,0,... with exactly one req_ready high each cycle and no idle cycles.
- out_valid=1 with out_ready=0 for 4 cycles and req_valid=5'b10000 -> out_flit stable and req_ready=0 for those cycles; when out_ready returns to 1, the core flit is loaded on the next edge with out_src=4.
- Requesters 1 and 3 valid, rr_ptr=1 -> requester 3 granted first, then 1. Requester 1 drops valid before its turn -> no grant to 1, and rr_ptr stays at 3.
- Reset asserted while out_valid=1 -> next edge out_valid=0, out_src=0, and the next grant goes to requester 0 given req_valid=5'b11111.
- With NOC_ARB_STATS_EN defined: 70000 grants to requester 2 -> its stat_grants field reads 16'hFFFF; the other fields read 0.
